// File: rtl/processor_help.sv
// Shared core-wide constants and types for rename, dispatch and retirement.
// Holds the RetireEntry record and the small helpers used on both sides of the ROB.
package processor_help;

    localparam int SUPER_SCALAR_WIDTH           = 2;
    localparam int PHYSICAL_REGISTER_FILE_SIZE  = 64;
    localparam int ARCHITECTURAL_REGISTER_COUNT = 32;
    localparam int ROB_DEPTH                    = 32;

    localparam int W  = SUPER_SCALAR_WIDTH;
    localparam int PW = $clog2(PHYSICAL_REGISTER_FILE_SIZE);
    localparam int AW = $clog2(ARCHITECTURAL_REGISTER_COUNT);
    localparam int TW = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic          writes_register;
        logic [AW-1:0] arch_destination;
        logic [PW-1:0] physical_destination;
    } RetireEntry;

    localparam RetireEntry EMPTY_ENTRY = '{
        writes_register:      1'b0,
        arch_destination:     {AW{1'b0}},
        physical_destination: {PW{1'b0}}
    };

    // Architectural register zero is hardwired, so it never owns a physical register.
    function automatic logic writes_to_register(input logic          has_destination,
                                                input logic [AW-1:0] arch_destination);
        return has_destination && (arch_destination != {AW{1'b0}});
    endfunction

    // Forward distance from one ROB tag to another, widened so it compares against count.
    function automatic logic [TW:0] ring_distance(input logic [TW-1:0] from_tag,
                                                  input logic [TW-1:0] to_tag);
        logic [TW-1:0] diff;
        diff = to_tag - from_tag;
        return {1'b0, diff};
    endfunction

endpackage

// File: rtl/retirement_rat.sv
// Committed architectural-to-physical map with in-group forwarding.
// Emits the superseded physical registers packed into the low lanes, registered.
module retirement_rat
    import processor_help::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         retire_en,
    input  RetireEntry [W-1:0]   retire_entry,
    output logic [W-1:0]         freed_valid,
    output logic [W-1:0][PW-1:0] freed_register
);

    localparam int RW = $clog2(W + 1);

    logic [PW-1:0]        rat_r [ARCHITECTURAL_REGISTER_COUNT];
    logic [W-1:0]         writer_s;
    logic [W-1:0][PW-1:0] lane_freed_s;
    logic [W-1:0][RW-1:0] rank_s;
    logic [W-1:0]         packed_valid_s;
    logic [W-1:0][PW-1:0] packed_reg_s;

    // Lanes that both retire this cycle and own a destination register
    always_comb begin
        writer_s = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            writer_s[i] = retire_en[i] & retire_entry[i].writes_register;
        end
    end

    // Old mapping per lane; the youngest older writer of the same register overrides the table
    always_comb begin
        lane_freed_s = {(W*PW){1'b0}};
        for (int i = 0; i < W; i++) begin
            lane_freed_s[i] = rat_r[retire_entry[i].arch_destination];
            for (int j = 0; j < i; j++) begin
                lane_freed_s[i] = (writer_s[j] &&
                                   (retire_entry[j].arch_destination == retire_entry[i].arch_destination))
                                  ? retire_entry[j].physical_destination
                                  : lane_freed_s[i];
            end
        end
    end

    // Output slot of each writer: number of older writers in the same group
    always_comb begin
        rank_s = {(W*RW){1'b0}};
        for (int i = 1; i < W; i++) begin
            rank_s[i] = rank_s[i-1] + RW'(writer_s[i-1]);
        end
    end

    // Compact writers into lanes 0..k-1; at most one writer maps to each slot
    always_comb begin
        packed_valid_s = {W{1'b0}};
        packed_reg_s   = {(W*PW){1'b0}};
        for (int k = 0; k < W; k++) begin
            for (int i = k; i < W; i++) begin
                packed_valid_s[k] = packed_valid_s[k] | (writer_s[i] & (rank_s[i] == RW'(k)));
                packed_reg_s[k]   = packed_reg_s[k] |
                                    ({PW{writer_s[i] & (rank_s[i] == RW'(k))}} & lane_freed_s[i]);
            end
        end
    end

    // Table update in program order (later lane wins) and registered free-list outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < ARCHITECTURAL_REGISTER_COUNT; a++) begin
                rat_r[a] <= PW'(a);
            end
            freed_valid    <= {W{1'b0}};
            freed_register <= {(W*PW){1'b0}};
        end else begin
            for (int i = 0; i < W; i++) begin
                if (writer_s[i]) begin
                    rat_r[retire_entry[i].arch_destination] <= retire_entry[i].physical_destination;
                end
            end
            freed_valid    <= packed_valid_s;
            freed_register <= packed_reg_s;
        end
    end

endmodule

// File: rtl/retire_unit.sv
// In-order retirement backend: ROB ring buffer, completion tracking and head-of-queue
// retire selection; freed physical registers come out of the retirement RAT.
module retire_unit
    import processor_help::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    output logic                 dispatch_ready_out,
    input  logic                 dispatch_valid_in,
    input  RetireEntry [W-1:0]   dispatch_payload_in,
    output logic [TW-1:0]        dispatch_tag_out,
    input  logic [W-1:0]         complete_valid_in,
    input  logic [W-1:0][TW-1:0] complete_tag_in,
    output logic [W-1:0]         retire_valid_out,
    output logic [W-1:0][PW-1:0] retire_freed_register_out
);

    localparam logic [TW:0] READY_LIMIT = (TW+1)'(ROB_DEPTH - W);

    RetireEntry           entry_r [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] done_r;
    logic [TW-1:0]        head_r;
    logic [TW-1:0]        tail_r;
    logic [TW:0]          count_r;

    logic                 ready_s;
    logic                 handshake_s;
    logic                 contiguous_s;
    logic [W-1:0]         retire_en_s;
    logic [TW:0]          retire_n_s;
    logic [W-1:0][TW-1:0] head_slot_s;
    RetireEntry [W-1:0]   head_entry_s;

    // Space is judged on registered occupancy only; same-cycle retirement earns no credit.
    assign ready_s            = (count_r <= READY_LIMIT);
    assign handshake_s        = dispatch_valid_in & ready_s;
    assign dispatch_ready_out = ready_s;
    assign dispatch_tag_out   = tail_r;

    // Contiguous done prefix from head, capped by lane count and occupancy
    always_comb begin
        head_slot_s  = {(W*TW){1'b0}};
        head_entry_s = {(W*$bits(RetireEntry)){1'b0}};
        retire_en_s  = {W{1'b0}};
        retire_n_s   = {(TW+1){1'b0}};
        contiguous_s = 1'b1;
        for (int i = 0; i < W; i++) begin
            head_slot_s[i]  = head_r + TW'(i);
            head_entry_s[i] = entry_r[head_slot_s[i]];
            contiguous_s    = contiguous_s & ((TW+1)'(i) < count_r) & done_r[head_slot_s[i]];
            retire_en_s[i]  = contiguous_s;
            retire_n_s      = retire_n_s + (TW+1)'(contiguous_s);
        end
    end

    // Ring buffer, done bits and pointers; clears are ordered after sets so they win
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_r  <= {TW{1'b0}};
            tail_r  <= {TW{1'b0}};
            count_r <= {(TW+1){1'b0}};
            done_r  <= {ROB_DEPTH{1'b0}};
            for (int d = 0; d < ROB_DEPTH; d++) begin
                entry_r[d] <= EMPTY_ENTRY;
            end
        end else begin
            for (int j = 0; j < W; j++) begin
                if (complete_valid_in[j] && (ring_distance(head_r, complete_tag_in[j]) < count_r)) begin
                    done_r[complete_tag_in[j]] <= 1'b1;
                end
            end
            for (int i = 0; i < W; i++) begin
                if (retire_en_s[i]) begin
                    done_r[head_slot_s[i]] <= 1'b0;
                end
            end
            if (handshake_s) begin
                for (int i = 0; i < W; i++) begin
                    entry_r[tail_r + TW'(i)] <= dispatch_payload_in[i];
                    done_r[tail_r + TW'(i)]  <= 1'b0;
                end
                tail_r  <= tail_r + TW'(W);
                count_r <= count_r + (TW+1)'(W) - retire_n_s;
            end else begin
                count_r <= count_r - retire_n_s;
            end
            head_r <= head_r + retire_n_s[TW-1:0];
        end
    end

    retirement_rat u_retirement_rat (
        .clk            (clk_in),
        .rst            (rst_in),
        .retire_en      (retire_en_s),
        .retire_entry   (head_entry_s),
        .freed_valid    (retire_valid_out),
        .freed_register (retire_freed_register_out)
    );

endmodule

// File: doc/retire_unit.md
# retire_unit

In-order retirement backend for the out-of-order core. It sits between rename/dispatch and the rename free list. It accepts renamed instruction groups from dispatch and records completions from execute. It then retires completed instructions in program order, up to SUPER_SCALAR_WIDTH per cycle, and returns each superseded physical register to the rename free list through the packed retire_valid/retire_freed_register interface.

## Interface
- SUPER_SCALAR_WIDTH, from processor_help: lanes per group (W).
- PHYSICAL_REGISTER_FILE_SIZE, from processor_help: physical register count; PW = $clog2 of it.
- ARCHITECTURAL_REGISTER_COUNT, from processor_help: architectural register count; AW = $clog2 of it.
- ROB_DEPTH, from processor_help, default 32: entry count. Power of 2 and a multiple of W. TW = $clog2(ROB_DEPTH).

Ports:
- clk_in  in  1  single clock.
- rst_in  in  1  reset, asynchronous and active-high.
- dispatch_ready_out  out  1  at least W free entries.
- dispatch_valid_in  in  1  a group is offered.
- dispatch_payload_in  in  RetireEntry[W]  per lane: writes_register, arch_destination (AW), physical_destination (PW).
- dispatch_tag_out  out  TW  tag of lane 0 of the offered group; lane i gets (tag+i) mod ROB_DEPTH. Combinational.
- complete_valid_in  in  1[W]  completion strobes.
- complete_tag_in  in  TW[W]  tags of completing entries.
- retire_valid_out  out  1[W]  packed freed-register strobes; lanes 0..k-1 only.
- retire_freed_register_out  out  PW[W]  physical register to return to the free list.

## Operation
- State:
  - Circular buffer of ROB_DEPTH entries, each holding {writes_register, arch_destination, physical_destination, done}.
  - head, tail, count (TW+1 bits).
  - retirement RAT: ARCHITECTURAL_REGISTER_COUNT × PW.
- Reset (async):
  - head = tail = count = 0; all done = 0.
  - retirement RAT[i] = i.
  - retire_valid_out all 0; retire_freed_register_out all 0.
- Dispatch:
  - dispatch_ready_out = (ROB_DEPTH − count ≥ W), computed from registered count only. No credit is taken for same-cycle retirement.
  - On handshake, write W entries at tail..tail+W−1 with done = 0, and advance tail by W mod ROB_DEPTH.
  - Every lane is enqueued, including lanes that do not write a register.
- Completion:
  - Each valid lane sets done on entry complete_tag_in[j].
  - Duplicate tags in one cycle are legal and idempotent.
  - Completion to an unoccupied slot is a protocol error and is ignored; the verification bench asserts it never occurs.
- Retire selection (combinational):
  - n = length of the contiguous prefix of done entries starting at head, capped at min(W, count).
  - Only entries already done in registered state qualify. A completion in the same cycle does not.
- Retire effects:
  - For each retiring entry with writes_register, in program order:
    - freed = retirement RAT[arch_destination], after applying updates from earlier retiring entries in the same group;
    - retirement RAT[arch_destination] ← physical_destination.
  - Freed registers are packed into lanes 0..k−1 of the outputs, where k = number of retiring writers. Non-writers consume retire bandwidth but emit nothing.
  - head advances by n mod ROB_DEPTH; done bits of retired slots are cleared.
  - count_next = count + (dispatch handshake ? W : 0) − n.
- No flush/recovery path in this block.

## Timing
- Retire outputs are registered and valid for exactly one cycle per retire event; all lanes are 0 when k = 0.
- Completion sampled at edge E: done visible after E; earliest retire output visible after edge E+1.
- Dispatch sampled at edge E: the entry can be completed starting at edge E+1.
- Boundary cases:
  - Full (count = ROB_DEPTH): ready = 0. Retirement still proceeds.
  - Empty: n = 0.
  - head/tail wrap modulo ROB_DEPTH.
  - Simultaneous dispatch and retire: both apply.
  - Reset asserted mid-operation: all state and outputs clear immediately, without waiting for a clock edge.

## Structure
- processor_help gains:
  - RetireEntry typedef;
  - ROB_DEPTH constant;
  - writes_to_register(), shared with rename to fill writes_register.
- Sub-module: retirement_rat, holding the table plus W-way in-group forwarding, and producing freed registers and packed lanes.
- Buffer, pointers and completion logic stay in retire_unit.

## Test plan
Test configuration: W=2, 32 architectural, 64 physical, ROB_DEPTH=32.

1. Reset: outputs 0, ready = 1. Release, then dispatch {rd=5,p=32},{rd=7,p=33}, complete tag 1 then tag 0 one cycle apart. Expect a single retire cycle with lanes {5,7}, both valid, two cycles after the tag 0 completion.
2. Same destination within one group: {rd=5,p=32},{rd=5,p=33}, both completed together. Expect freed {5,32}.
3. Non-writer in lane 0 (writes_register = 0) and a writer {rd=3,p=40} in lane 1, both done. Expect retire_valid_out = {1,0} with lane 0 = 3.
4. Dispatch 16 groups with no completions: ready drops to 0 once count = 32. Complete tags 0 and 1: ready returns to 1 after retire. Continue through a tail wrap to tag 0.
5. Head blocked: complete tags 1..5 but not tag 0. Expect no retire output. Then complete tag 0: expect retires of 2, 2, 2 over consecutive cycles.
6. Assert rst_in asynchronously between clock edges while retire_valid_out is high: outputs drop immediately, and the retirement RAT reads identity afterwards.
